// File: rtl/otter_hazard_unit.sv
// Hazard/forwarding controller for the pipelined OTTER RV32I core.
// Optional stall/flush statistics counters are built when OTTER_HAZARD_STATS_EN is defined.
module otter_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_DEPTH  = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned BR_PENALTY = 2,
  localparam int unsigned SW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  output logic              stall,
  output logic              flush,
  output logic              freeze,
  output logic [SW-1:0]     fwd_sel_rs1,
  output logic [SW-1:0]     fwd_sel_rs2,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_flush
);

  typedef enum logic {StRun, StFlush} state_e;

  state_e                 state_q;
  logic [2:0]             cnt_q;
  logic [FWD_DEPTH-1:0]   slot_valid;
  logic [FWD_DEPTH-1:0]   slot_rw;
  logic [FWD_DEPTH-1:0]   slot_mr;
  logic [REG_AW-1:0]      slot_rd [FWD_DEPTH];
  logic                   ld_hit1, ld_hit2;
  logic                   found1, found2;
  logic                   br_take;

  // Search from the youngest slot; the first hit wins.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    ld_hit1     = 1'b0;
    ld_hit2     = 1'b0;
    found1      = 1'b0;
    found2      = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (!found1 && id_use_rs1 && id_rs1 != '0 && slot_valid[k] && slot_rw[k] &&
          slot_rd[k] == id_rs1) begin
        found1      = 1'b1;
        fwd_sel_rs1 = SW'(k + 1);
        ld_hit1     = slot_mr[k] && (k < LOAD_LAT);
      end
      if (!found2 && id_use_rs2 && id_rs2 != '0 && slot_valid[k] && slot_rw[k] &&
          slot_rd[k] == id_rs2) begin
        found2      = 1'b1;
        fwd_sel_rs2 = SW'(k + 1);
        ld_hit2     = slot_mr[k] && (k < LOAD_LAT);
      end
    end
  end

  assign br_take = (state_q == StRun) && ex_br_taken && slot_valid[0];
  assign flush   = (state_q == StFlush) || br_take;
  assign stall   = (ld_hit1 || ld_hit2) && !flush;
  assign freeze  = mem_busy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slot_valid <= '0;
      slot_rw    <= '0;
      slot_mr    <= '0;
      for (int unsigned i = 0; i < FWD_DEPTH; i++) slot_rd[i] <= '0;
    end else if (!mem_busy) begin
      for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
        slot_valid[i] <= slot_valid[i-1];
        slot_rw[i]    <= slot_rw[i-1];
        slot_mr[i]    <= slot_mr[i-1];
        slot_rd[i]    <= slot_rd[i-1];
      end
      if (id_valid && !stall && !flush) begin
        slot_valid[0] <= 1'b1;
        slot_rw[0]    <= id_reg_write;
        slot_mr[0]    <= id_mem_read;
        slot_rd[0]    <= id_rd;
      end else begin
        slot_valid[0] <= 1'b0;
        slot_rw[0]    <= 1'b0;
        slot_mr[0]    <= 1'b0;
        slot_rd[0]    <= '0;
      end
    end
  end

  // cnt_q counts flush cycles still owed after the branch cycle itself.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else if (!mem_busy) begin
      case (state_q)
        StRun: begin
          if (br_take && BR_PENALTY > 1) begin
            state_q <= StFlush;
            cnt_q   <= 3'(BR_PENALTY - 1);
          end
        end
        StFlush: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef OTTER_HAZARD_STATS_EN
  logic [31:0] stat_stall_q, stat_flush_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stat_stall_q <= '0;
      stat_flush_q <= '0;
    end else if (!mem_busy) begin
      if (stall) stat_stall_q <= stat_stall_q + 32'd1;
      if (flush) stat_flush_q <= stat_flush_q + 32'd1;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_flush = stat_flush_q;
`else
  assign stat_stall = 32'h0;
  assign stat_flush = 32'h0;
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Scoreboard bench for otter_hazard_unit: directed scenarios then randomized traffic,
// checked against an instruction-history reference model.
module tb_otter_hazard_unit;

  localparam int D  = 3;
  localparam int LL = 1;
  localparam int BP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_br_taken, mem_busy;
  logic        stall, flush, freeze;
  logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
  logic [31:0] stat_stall, stat_flush;

  always #5 clk = ~clk;

  otter_hazard_unit #(
    .REG_AW(5), .FWD_DEPTH(D), .LOAD_LAT(LL), .BR_PENALTY(BP)
  ) dut (
    .CLK(clk), .RESET(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .freeze(freeze),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .stat_stall(stat_stall), .stat_flush(stat_flush)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ent_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        freeze;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] ss;
    logic [31:0] sf;
  } exp_t;

  // hist[k] is the instruction that entered EX k unfrozen cycles ago.
  ent_t        hist[$];
  exp_t        sbq[$];
  int          flush_rem;
  int unsigned m_ss, m_sf;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic use_i, input logic [4:0] rs,
                                 output logic [1:0] sel, output logic ld);
    sel = 2'd0;
    ld  = 1'b0;
    if (use_i && rs != 5'd0) begin
      for (int k = 0; k < hist.size(); k++) begin
        if (hist[k].v && hist[k].rw && hist[k].rd == rs) begin
          sel = 2'(k + 1);
          ld  = hist[k].mr && (k < LL);
          break;
        end
      end
    end
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back('0);
    flush_rem = 0;
    m_ss      = 0;
    m_sf      = 0;
  endtask

  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic br, input logic busy);
    exp_t e;
    logic ld1, ld2;
    ent_t n;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_br_taken = br; mem_busy = busy;
    lookup(u1, rs1, e.s1, ld1);
    lookup(u2, rs2, e.s2, ld2);
    e.flush  = (flush_rem > 0) || (br && hist[0].v);
    e.stall  = (ld1 || ld2) && !e.flush;
    e.freeze = busy;
`ifdef OTTER_HAZARD_STATS_EN
    e.ss = m_ss;
    e.sf = m_sf;
`else
    e.ss = 32'h0;
    e.sf = 32'h0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    if (!busy) begin
      if (e.stall) m_ss++;
      if (e.flush) m_sf++;
      if (flush_rem > 0) flush_rem--;
      else if (br && hist[0].v) flush_rem = BP - 1;
      n = '0;
      if (v && !e.stall && !e.flush) begin
        n.v = 1'b1; n.rd = rd; n.rw = rw; n.mr = mr;
      end
      hist.push_front(n);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic idle(input logic busy);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, busy);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_br_taken = 0; mem_busy = 0;
    rst = 1'b1;
    model_reset();
    sbq.push_back('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("freeze", 32'(freeze), 32'(e.freeze));
        chk("fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(e.s1));
        chk("fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(e.s2));
        chk("stat_stall", stat_stall, e.ss);
        chk("stat_flush", stat_flush, e.sf);
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_br_taken = 0; mem_busy = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // addi x5 then add x6,x5,x5
    step(1, 5'd0, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0);
    step(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0, 0);
    idle(0); idle(0); idle(0);

    // lw x7 then add x8,x7,x0: one stall then forward from slot1
    step(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0);
    step(1, 5'd7, 5'd0, 1, 1, 5'd8, 1, 0, 0, 0);
    step(1, 5'd7, 5'd0, 1, 1, 5'd8, 1, 0, 0, 0);
    idle(0); idle(0); idle(0);

    // two writers of x3, youngest wins; x0 writes never forward
    step(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0);
    step(1, 5'd3, 5'd3, 1, 1, 5'd9, 1, 0, 0, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0);
    step(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0, 0, 0);
    idle(0); idle(0); idle(0);

    // branch taken while load-use is pending: flush wins
    step(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0);
    step(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0, 1, 0);
    step(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0, 0, 0);
    step(1, 5'd7, 5'd0, 1, 0, 5'd8, 1, 0, 0, 0);
    idle(0); idle(0); idle(0);

    // mem_busy for three cycles mid-flush
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    step(1, 5'd2, 5'd0, 1, 0, 5'd4, 1, 0, 1, 0);
    idle(1); idle(1); idle(1);
    idle(0); idle(0); idle(0);

    // reset in the middle of a flush
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
    do_reset();
    idle(0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0);
      if (i == 200) do_reset();
    end
    idle(0);

    #20;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
